ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address ops plus a 32-iteration shift-add MULTU
// that stalls upstream through busy and deposits its product in HI/LO.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic [4:0]  dest,
  output logic        busy,
  output logic        out_valid,
  output logic [5:0]  out_opcode,
  output logic [31:0] out_result,
  output logic [31:0] out_rt_value,
  output logic [4:0]  out_dest,
  output logic        out_reg_write
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [5:0] MUL_ITERATIONS = 6'd32;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t      state, state_next;
  logic [5:0]  count, count_next;
  logic [63:0] mcand, mcand_next;
  logic [31:0] mplier, mplier_next;
  logic [63:0] prod, prod_next;
  logic [31:0] hi, lo;

  logic        accept;
  logic        start_mul;
  logic        mul_done;
  logic [31:0] alu_result;
  logic        alu_reg_write;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign busy     = (state == S_MUL);
  assign accept   = in_valid && !busy;
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  // Instruction decode and single-cycle datapath.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    alu_result    = '0;
    alu_reg_write = 1'b0;
    start_mul     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:   begin alu_result = rs_value + rt_value;           alu_reg_write = 1'b1; end
          FN_SUB:   begin alu_result = rs_value - rt_value;           alu_reg_write = 1'b1; end
          FN_AND:   begin alu_result = rs_value & rt_value;           alu_reg_write = 1'b1; end
          FN_OR:    begin alu_result = rs_value | rt_value;           alu_reg_write = 1'b1; end
          FN_SLT:   begin
            alu_result    = {31'b0, ($signed(rs_value) < $signed(rt_value))};
            alu_reg_write = 1'b1;
          end
          FN_SLL:   begin alu_result = rt_value << shamt;             alu_reg_write = 1'b1; end
          FN_SRL:   begin alu_result = rt_value >> shamt;             alu_reg_write = 1'b1; end
          FN_MFHI:  begin alu_result = hi;                            alu_reg_write = 1'b1; end
          FN_MFLO:  begin alu_result = lo;                            alu_reg_write = 1'b1; end
          FN_MULTU: start_mul = 1'b1;
          default:  ;
        endcase
      end
      OP_ADDI: begin alu_result = rs_value + imm_sext; alu_reg_write = 1'b1; end
      OP_ANDI: begin alu_result = rs_value & imm_zext; alu_reg_write = 1'b1; end
      OP_ORI:  begin alu_result = rs_value | imm_zext; alu_reg_write = 1'b1; end
      OP_LW,
      OP_SW:   alu_result = rs_value + imm_sext;
      default: ;
    endcase
  end

  // Multiplier control: one shift-add step per edge while in S_MUL.
  always_comb begin
    state_next  = state;
    count_next  = count;
    mcand_next  = mcand;
    mplier_next = mplier;
    prod_next   = prod;
    mul_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && start_mul) begin
          state_next  = S_MUL;
          count_next  = MUL_ITERATIONS;
          mcand_next  = {32'b0, rs_value};
          mplier_next = rt_value;
          prod_next   = '0;
        end
      end
      S_MUL: begin
        prod_next   = prod + (mplier[0] ? mcand : 64'd0);
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count - 6'd1;
        if (count == 6'd1) begin
          mul_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      count         <= '0;
      mcand         <= '0;
      mplier        <= '0;
      prod          <= '0;
      hi            <= '0;
      lo            <= '0;
      out_valid     <= 1'b0;
      out_opcode    <= '0;
      out_result    <= '0;
      out_rt_value  <= '0;
      out_dest      <= '0;
      out_reg_write <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      mcand         <= mcand_next;
      mplier        <= mplier_next;
      prod          <= prod_next;
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      if (mul_done) begin
        hi            <= prod_next[63:32];
        lo            <= prod_next[31:0];
        out_valid     <= 1'b1;
        out_opcode    <= OP_RTYPE;
        out_result    <= prod_next[31:0];
        out_dest      <= '0;
      end else if (accept && !start_mul) begin
        out_valid     <= 1'b1;
        out_opcode    <= opcode;
        out_result    <= alu_result;
        out_rt_value  <= rt_value;
        out_dest      <= dest;
        out_reg_write <= alu_reg_write;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an instruction-level reference model
// (MULTU modelled as a 32-cycle wait followed by a native 64-bit product).
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic [4:0]  dest;
  logic        busy;
  logic        out_valid;
  logic [5:0]  out_opcode;
  logic [31:0] out_result;
  logic [31:0] out_rt_value;
  logic [4:0]  out_dest;
  logic        out_reg_write;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_busy_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pending = '0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .shamt(shamt), .imm(imm), .rs_value(rs_value), .rt_value(rt_value), .dest(dest),
    .busy(busy), .out_valid(out_valid), .out_opcode(out_opcode), .out_result(out_result),
    .out_rt_value(out_rt_value), .out_dest(out_dest), .out_reg_write(out_reg_write)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_exec(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] sh, input logic [15:0] im,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic w);
    logic [31:0] se;
    se = 32'($signed(im));
    r = 0;
    w = 0;
    if (op == 6'd0) begin
      case (fn)
        6'd32: begin r = a + b; w = 1; end
        6'd34: begin r = a - b; w = 1; end
        6'd36: begin r = a & b; w = 1; end
        6'd37: begin r = a | b; w = 1; end
        6'd42: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; w = 1; end
        6'd0:  begin r = b << sh; w = 1; end
        6'd2:  begin r = b >> sh; w = 1; end
        6'd16: begin r = m_hi; w = 1; end
        6'd18: begin r = m_lo; w = 1; end
        default: ;
      endcase
    end else if (op == 6'd8) begin r = a + se; w = 1; end
    else if (op == 6'd12) begin r = a & {16'd0, im}; w = 1; end
    else if (op == 6'd13) begin r = a | {16'd0, im}; w = 1; end
    else if (op == 6'd35 || op == 6'd43) r = a + se;
  endfunction

  // Advance one clock edge with the current inputs, then compare against the model.
  task automatic cycle();
    logic        e_valid, e_wr, e_full;
    logic [31:0] e_res, e_rt;
    logic [5:0]  e_op;
    logic [4:0]  e_dest;
    e_valid = 0; e_wr = 0; e_full = 0; e_res = 0; e_rt = 0; e_op = 0; e_dest = 0;
    if (rst) begin
      m_busy_left = 0;
      m_hi = 0;
      m_lo = 0;
      e_full = 1;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        {m_hi, m_lo} = m_pending;
        e_valid = 1;
        e_res   = m_lo;
      end
    end else if (in_valid) begin
      if (opcode == 6'd0 && funct == 6'd25) begin
        m_busy_left = 32;
        m_pending   = 64'(rs_value) * 64'(rt_value);
      end else begin
        ref_exec(opcode, funct, shamt, imm, rs_value, rt_value, e_res, e_wr);
        e_valid = 1;
        e_full  = 1;
        e_op    = opcode;
        e_rt    = rt_value;
        e_dest  = dest;
      end
    end
    @(posedge clk);
    #1;
    check("busy", busy, m_busy_left > 0);
    check("out_valid", out_valid, e_valid);
    if (e_valid || rst) begin
      check("out_result", out_result, e_res);
      check("out_reg_write", out_reg_write, e_wr);
      check("out_opcode", out_opcode, e_op);
    end
    if (e_full) begin
      check("out_rt_value", out_rt_value, e_rt);
      check("out_dest", out_dest, e_dest);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    in_valid = v;
    opcode   = op;
    funct    = fn;
    rs_value = a;
    rt_value = b;
    imm      = im;
    shamt    = 5'($urandom_range(0, 31));
    dest     = 5'($urandom_range(0, 31));
  endtask

  task automatic rand_instr();
    logic [5:0] ops [7];
    logic [5:0] fns [11];
    ops = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd35, 6'd43, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2, 6'd16, 6'd18, 6'd25, 6'd63};
    drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 6)], fns[$urandom_range(0, 10)],
          $urandom, $urandom, 16'($urandom));
    if ($urandom_range(0, 15) == 0) opcode = 6'($urandom);
    if ($urandom_range(0, 15) == 0) funct  = 6'($urandom);
  endtask

  initial begin
    int busy_cycles;
    rst = 1;
    drive(0, 6'd0, 6'd0, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;

    // ADD overflow wraps, single-cycle valid pulse
    drive(1, 6'd0, 6'd32, 32'h7FFF_FFFF, 32'd1, 0);
    cycle();
    check("add_wrap", out_result, 32'h8000_0000);
    in_valid = 0;
    cycle();

    // lw / sw effective address with negative offset
    drive(1, 6'd35, 6'd0, 32'h100, 32'h1234, 16'hFFFC);
    cycle();
    check("lw_addr", out_result, 32'h0000_00FC);
    drive(1, 6'd43, 6'd0, 32'h100, 32'hDEAD_BEEF, 16'hFFFC);
    cycle();
    check("sw_data", out_rt_value, 32'hDEAD_BEEF);

    // SLT signed, unknown opcode is a NOP
    drive(1, 6'd0, 6'd42, 32'hFFFF_FFFF, 32'd1, 0);
    cycle();
    check("slt_neg", out_result, 32'd1);
    drive(1, 6'd63, 6'd32, 32'h5, 32'h6, 16'h7);
    cycle();
    check("nop_wr", out_reg_write, 1'b0);

    // MULTU max x max with an ADD held on the inputs throughout
    drive(1, 6'd0, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    cycle();
    drive(1, 6'd0, 6'd32, 32'd10, 32'd20, 0);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      cycle();
      if (busy === 1'b1) busy_cycles++;
    end
    check("mul_busy_len", busy_cycles, 32);
    check("mul_lo_result", out_result, 32'h0000_0001);
    cycle();                               // held ADD accepted exactly here
    check("held_add", out_result, 32'd30);
    drive(1, 6'd0, 6'd16, 0, 0, 0);
    cycle();
    check("mfhi", out_result, 32'hFFFF_FFFE);
    drive(1, 6'd0, 6'd18, 0, 0, 0);
    cycle();
    check("mflo", out_result, 32'h0000_0001);

    // Reset at iteration 10 of a multiply, with in_valid also high
    drive(1, 6'd0, 6'd25, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    cycle();
    in_valid = 0;
    for (int i = 0; i < 9; i++) cycle();
    rst = 1;
    drive(1, 6'd0, 6'd32, 32'd1, 32'd1, 0);
    cycle();
    rst = 0;
    in_valid = 0;
    for (int i = 0; i < 30; i++) cycle();
    drive(1, 6'd0, 6'd16, 0, 0, 0);
    cycle();
    check("hi_after_abort", out_result, 32'd0);
    drive(1, 6'd0, 6'd18, 0, 0, 0);
    cycle();
    check("lo_after_abort", out_result, 32'd0);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 1500; i++) begin
      rand_instr();
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;
    in_valid = 0;
    for (int i = 0; i < 40; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
